// File: rtl/tdm_mux16_scan_if.sv
// Bus between the 16:1 TDM scanner and its consumer.
// master = the scanner side, slave = the downstream consumer and stimulus side.
interface tdm_mux16_scan_if #(
    parameter int W = 1
);
    logic            e;      // active-low scan enable
    logic [16*W-1:0] d;      // channel k = d[k*W +: W]
    logic            rdy;    // downstream ready
    logic [W-1:0]    y;      // presented channel data
    logic [3:0]      s;      // presented channel index (demux select)
    logic            valid;  // y/s hold a channel awaiting acceptance
    logic            frame;  // channel 0 of a frame is presented

    modport master (
        input  e, d, rdy,
        output y, s, valid, frame
    );

    modport slave (
        output e, d, rdy,
        input  y, s, valid, frame
    );
endinterface

// File: rtl/tdm_mux16_scan.sv
// 16:1 time-division scanner: snapshots sixteen W-bit channels at frame start and
// presents them one per valid/ready transfer with the channel index on s.
// Optional idle gap of GAP cycles between frames. All outputs registered.
module tdm_mux16_scan #(
    parameter int W   = 1,
    parameter int GAP = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    tdm_mux16_scan_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Counter reload; only meaningful when GAP > 0
    localparam logic [7:0] GAP_LD = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

    state_t             state;
    logic [15:0][W-1:0] snap;
    logic [7:0]         gap_cnt;
    logic               xfer;

    assign xfer = bus.valid & bus.rdy;

    // Single-block FSM: enable drop has priority over any transfer or load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            snap      <= '0;
            gap_cnt   <= '0;
            bus.y     <= '0;
            bus.s     <= '0;
            bus.valid <= 1'b0;
            bus.frame <= 1'b0;
        end else if (bus.e) begin
            // abandon any frame in progress
            state     <= ST_IDLE;
            bus.y     <= '0;
            bus.s     <= '0;
            bus.valid <= 1'b0;
            bus.frame <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    snap      <= bus.d;
                    bus.y     <= bus.d[W-1:0];
                    bus.s     <= 4'd0;
                    bus.valid <= 1'b1;
                    bus.frame <= 1'b1;
                    state     <= ST_SEND;
                end
                ST_SEND: begin
                    if (xfer) begin
                        if (bus.s != 4'd15) begin
                            bus.s     <= bus.s + 4'd1;
                            bus.y     <= snap[bus.s + 4'd1];
                            bus.frame <= 1'b0;
                        end else if (GAP == 0) begin
                            // back-to-back frame, fresh snapshot
                            snap      <= bus.d;
                            bus.y     <= bus.d[W-1:0];
                            bus.s     <= 4'd0;
                            bus.valid <= 1'b1;
                            bus.frame <= 1'b1;
                        end else begin
                            bus.y     <= '0;
                            bus.s     <= 4'd0;
                            bus.valid <= 1'b0;
                            bus.frame <= 1'b0;
                            gap_cnt   <= GAP_LD;
                            state     <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == 8'd0) begin
                        snap      <= bus.d;
                        bus.y     <= bus.d[W-1:0];
                        bus.s     <= 4'd0;
                        bus.valid <= 1'b1;
                        bus.frame <= 1'b1;
                        state     <= ST_SEND;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    bus.y     <= '0;
                    bus.s     <= '0;
                    bus.valid <= 1'b0;
                    bus.frame <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdm_mux16_scan.sv
// Self-checking bench for tdm_mux16_scan. Three instances cover W=1/GAP=0,
// W=1/GAP=3 and W=8/GAP=0. Inputs change and outputs are sampled on negedge.
module tb_tdm_mux16_scan;

    typedef struct {
        logic [7:0] y;
        logic [3:0] s;
        logic       frame;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sbq[$];

    tdm_mux16_scan_if #(.W(1)) bus_a ();
    tdm_mux16_scan_if #(.W(1)) bus_g ();
    tdm_mux16_scan_if #(.W(8)) bus_w ();

    tdm_mux16_scan #(.W(1), .GAP(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    tdm_mux16_scan #(.W(1), .GAP(3)) dut_g (.clk(clk), .rst_n(rst_n), .bus(bus_g));
    tdm_mux16_scan #(.W(8), .GAP(0)) dut_w (.clk(clk), .rst_n(rst_n), .bus(bus_w));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // queue the 16 transfers expected for one W=1 frame of dv
    task automatic push_bits(input logic [15:0] dv);
        exp_t e;
        for (int k = 0; k < 16; k++) begin
            e.y     = {7'd0, dv[k]};
            e.s     = 4'(k);
            e.frame = (k == 0);
            sbq.push_back(e);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus_a.valid !== 1'b0 || bus_a.s !== 4'd0 || bus_a.y !== 1'b0 || bus_a.frame !== 1'b0) begin
            errors++;
            $display("FAIL reset_a: valid=%b s=%0d y=%b frame=%b, want all 0", bus_a.valid, bus_a.s, bus_a.y, bus_a.frame);
        end
        checks++;
        if (bus_g.valid !== 1'b0 || bus_w.valid !== 1'b0 || bus_w.y !== 8'd0 || bus_w.s !== 4'd0) begin
            errors++;
            $display("FAIL reset_gw: g.valid=%b w.valid=%b w.y=%h w.s=%0d, want 0", bus_g.valid, bus_w.valid, bus_w.y, bus_w.s);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_a.valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: valid=%b want 0 while e=1", bus_a.valid);
        end
    endtask

    // two back-to-back frames of A5C3, rdy always high
    task automatic test_stream();
        exp_t ex;
        sbq.delete();
        push_bits(16'hA5C3);
        push_bits(16'hA5C3);
        bus_a.d = 16'hA5C3; bus_a.rdy = 1'b1; bus_a.e = 1'b0;
        for (int i = 0; i < 40 && sbq.size() > 0; i++) begin
            @(negedge clk);
            checks++;
            if (bus_a.valid !== 1'b1) begin
                errors++;
                $display("FAIL stream_valid: valid=%b want 1 (remaining %0d)", bus_a.valid, sbq.size());
            end else begin
                ex = sbq.pop_front();
                checks++;
                if ({7'd0, bus_a.y} !== ex.y || bus_a.s !== ex.s || bus_a.frame !== ex.frame) begin
                    errors++;
                    $display("FAIL stream_data: y=%b s=%0d frame=%b, want y=%b s=%0d frame=%b",
                             bus_a.y, bus_a.s, bus_a.frame, ex.y[0], ex.s, ex.frame);
                end
            end
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL stream_timeout: %0d transfers missing, want 0", sbq.size());
        end
        bus_a.e = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_a.valid !== 1'b0 || bus_a.s !== 4'd0) begin
            errors++;
            $display("FAIL stream_stop: valid=%b s=%0d want 0/0", bus_a.valid, bus_a.s);
        end
    endtask

    // downstream stalls for five cycles on channel 0
    task automatic test_stall();
        bus_a.d = 16'h0001; bus_a.rdy = 1'b0; bus_a.e = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus_a.valid !== 1'b1 || bus_a.s !== 4'd0 || bus_a.y !== 1'b1 || bus_a.frame !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold[%0d]: valid=%b s=%0d y=%b frame=%b, want 1/0/1/1",
                         i, bus_a.valid, bus_a.s, bus_a.y, bus_a.frame);
            end
        end
        bus_a.rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_a.valid !== 1'b1 || bus_a.s !== 4'd1 || bus_a.y !== 1'b0 || bus_a.frame !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: valid=%b s=%0d y=%b frame=%b, want 1/1/0/0",
                     bus_a.valid, bus_a.s, bus_a.y, bus_a.frame);
        end
        bus_a.e = 1'b1;
        @(negedge clk);
    endtask

    // GAP=3 instance: exactly three idle cycles between frames
    task automatic test_gap();
        exp_t ex;
        int   idle;
        idle = 0;
        sbq.delete();
        push_bits(16'h3C96);
        push_bits(16'h3C96);
        bus_g.d = 16'h3C96; bus_g.rdy = 1'b1; bus_g.e = 1'b0;
        for (int i = 0; i < 60 && sbq.size() > 0; i++) begin
            @(negedge clk);
            if (bus_g.valid === 1'b1) begin
                ex = sbq.pop_front();
                checks++;
                if ({7'd0, bus_g.y} !== ex.y || bus_g.s !== ex.s || bus_g.frame !== ex.frame) begin
                    errors++;
                    $display("FAIL gap_data: y=%b s=%0d frame=%b, want y=%b s=%0d frame=%b",
                             bus_g.y, bus_g.s, bus_g.frame, ex.y[0], ex.s, ex.frame);
                end
            end else begin
                idle++;
            end
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL gap_timeout: %0d transfers missing, want 0", sbq.size());
        end
        checks++;
        if (idle != 3) begin
            errors++;
            $display("FAIL gap_len: idle cycles=%0d want 3", idle);
        end
        bus_g.e = 1'b1;
        @(negedge clk);
    endtask

    // W=8: d rewritten mid-frame must only show in the following frame
    task automatic test_snapshot();
        exp_t ex;
        logic [127:0] dv;
        sbq.delete();
        for (int k = 0; k < 16; k++) begin
            dv[k*8 +: 8] = 8'h10 + 8'(k);
            ex.y = 8'h10 + 8'(k); ex.s = 4'(k); ex.frame = (k == 0);
            sbq.push_back(ex);
        end
        for (int k = 0; k < 16; k++) begin
            ex.y = 8'hFF; ex.s = 4'(k); ex.frame = (k == 0);
            sbq.push_back(ex);
        end
        bus_w.d = dv; bus_w.rdy = 1'b1; bus_w.e = 1'b0;
        for (int i = 0; i < 40 && sbq.size() > 0; i++) begin
            @(negedge clk);
            if (bus_w.valid === 1'b1) begin
                ex = sbq.pop_front();
                checks++;
                if (bus_w.y !== ex.y || bus_w.s !== ex.s || bus_w.frame !== ex.frame) begin
                    errors++;
                    $display("FAIL snap_data: y=%h s=%0d frame=%b, want y=%h s=%0d frame=%b",
                             bus_w.y, bus_w.s, bus_w.frame, ex.y, ex.s, ex.frame);
                end
                if (sbq.size() >= 16 && ex.s == 4'd5) bus_w.d = '1;
            end
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL snap_timeout: %0d transfers missing, want 0", sbq.size());
        end
        bus_w.e = 1'b1;
        @(negedge clk);
    endtask

    // enable dropped at s=7 abandons the frame, restart is clean
    task automatic test_abort();
        bit found;
        found = 0;
        bus_a.d = 16'hA5C3; bus_a.rdy = 1'b1; bus_a.e = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_a.valid === 1'b1 && bus_a.s === 4'd7) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL abort_reach: s=%0d never reached 7", bus_a.s);
        end
        bus_a.e = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_a.valid !== 1'b0 || bus_a.s !== 4'd0 || bus_a.y !== 1'b0 || bus_a.frame !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: valid=%b s=%0d y=%b frame=%b, want all 0",
                     bus_a.valid, bus_a.s, bus_a.y, bus_a.frame);
        end
        bus_a.e = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_a.valid !== 1'b1 || bus_a.s !== 4'd0 || bus_a.y !== 1'b1 || bus_a.frame !== 1'b1) begin
            errors++;
            $display("FAIL abort_restart: valid=%b s=%0d y=%b frame=%b, want 1/0/1/1",
                     bus_a.valid, bus_a.s, bus_a.y, bus_a.frame);
        end
        bus_a.e = 1'b1;
        @(negedge clk);
    endtask

    // async reset mid-cycle at s=9, then restart from channel 0
    task automatic test_reset_mid();
        bit found;
        found = 0;
        bus_a.d = 16'hFFFF; bus_a.rdy = 1'b1; bus_a.e = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_a.valid === 1'b1 && bus_a.s === 4'd9) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rstmid_reach: s=%0d never reached 9", bus_a.s);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus_a.valid !== 1'b0 || bus_a.s !== 4'd0 || bus_a.y !== 1'b0 || bus_a.frame !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: valid=%b s=%0d y=%b frame=%b, want all 0 before edge",
                     bus_a.valid, bus_a.s, bus_a.y, bus_a.frame);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_a.valid !== 1'b1 || bus_a.s !== 4'd0 || bus_a.y !== 1'b1 || bus_a.frame !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_restart: valid=%b s=%0d y=%b frame=%b, want 1/0/1/1",
                     bus_a.valid, bus_a.s, bus_a.y, bus_a.frame);
        end
        @(negedge clk);
        checks++;
        if (bus_a.s !== 4'd1 || bus_a.frame !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_advance: s=%0d frame=%b, want 1/0", bus_a.s, bus_a.frame);
        end
        bus_a.e = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus_a.e = 1'b1; bus_a.d = '0; bus_a.rdy = 1'b0;
        bus_g.e = 1'b1; bus_g.d = '0; bus_g.rdy = 1'b0;
        bus_w.e = 1'b1; bus_w.d = '0; bus_w.rdy = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_gap();
        test_snapshot();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
